// File: rtl/ff_bank_arbiter_pkg.sv
// Shared encodings and helpers for the flip-flop bank arbiter.
package ff_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_READ   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXEC    = 2'b01,
        RECOVER = 2'b10,
        DONE    = 2'b11
    } state_e;

    localparam int CNT_W = 4;

    function automatic logic is_pulse_op(input op_e op);
        return (op == OP_CLEAR) || (op == OP_PRESET);
    endfunction

    function automatic logic [1:0] ack_vec(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ff_bank_arbiter_if.sv
// Requester and bank-side signals of the arbiter; master is the surrounding
// system (requesters plus bank Q), slave is the arbiter itself.
interface ff_bank_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] bank_data;
    logic             bank_clr;
    logic             bank_pre;
    logic [1:0]       ack;
    logic [WIDTH-1:0] rdata;
    logic             busy;

    modport master (
        output req, op0, op1, din0, din1, bank_q,
        input  bank_data, bank_clr, bank_pre, ack, rdata, busy
    );

    modport slave (
        input  req, op0, op1, din0, din1, bank_q,
        output bank_data, bank_clr, bank_pre, ack, rdata, busy
    );
endinterface

// File: rtl/ff_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to whichever requester was not
// granted at the last advance strobe.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio_r;  // 1: requester 1 wins a tie

    // One-hot grant from the current requests and tie-break pointer
    always_comb begin
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer moves to the requester that was not just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (advance) begin
            prio_r <= grant[0];
        end else begin
            prio_r <= prio_r;
        end
    end
endmodule

// File: rtl/ff_bank_arbiter.sv
// Shares one D flip-flop bank between two requesters and sequences the
// bank's DATA/CLR/PRE lines for load, clear, preset and read operations.
module ff_bank_arbiter
    import ff_bank_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    ff_bank_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

    state_e           state_r, state_nxt_s;
    op_e              op_r, op_nxt_s;
    logic             owner_r, owner_nxt_s;
    logic [WIDTH-1:0] data_r, data_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]       grant_s;
    logic             accept_s;
    logic             exec_load_s;
    logic             exec_read_s;

    logic [WIDTH-1:0] bank_data_r, bank_data_nxt_s;
    logic             bank_clr_r, bank_clr_nxt_s;
    logic             bank_pre_r, bank_pre_nxt_s;
    logic [1:0]       ack_r, ack_nxt_s;
    logic [WIDTH-1:0] rdata_r, rdata_nxt_s;
    logic             busy_r, busy_nxt_s;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (clr_n),
        .req     (bus.req),
        .advance (accept_s),
        .grant   (grant_s)
    );

    assign exec_load_s = (state_r == EXEC) && (op_r == OP_LOAD);
    assign exec_read_s = (state_r == EXEC) && (op_r == OP_READ);

    // State register plus the latched request (owner, op, data, pulse count)
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= IDLE;
            op_r    <= OP_LOAD;
            owner_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            owner_r <= owner_nxt_s;
            data_r  <= data_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; REQ is only looked at in IDLE
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        owner_nxt_s = owner_r;
        data_nxt_s  = data_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    accept_s    = 1'b1;
                    owner_nxt_s = grant_s[1];
                    op_nxt_s    = grant_s[1] ? op_e'(bus.op1) : op_e'(bus.op0);
                    data_nxt_s  = grant_s[1] ? bus.din1 : bus.din0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (is_pulse_op(op_r) && (cnt_r != PULSE_LAST)) begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = RECOVER;
                end
            end
            RECOVER: state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output values for the state being entered; a just-finished LOAD keeps
    // driving its data because BANK_Q only shows it after this edge
    always_comb begin
        bank_data_nxt_s = exec_load_s ? data_r : bus.bank_q;
        rdata_nxt_s     = exec_read_s ? bus.bank_q : rdata_r;
        bank_clr_nxt_s  = 1'b0;
        bank_pre_nxt_s  = 1'b0;
        ack_nxt_s       = 2'b00;
        busy_nxt_s      = (state_nxt_s != IDLE);
        case (state_nxt_s)
            EXEC: begin
                case (op_nxt_s)
                    OP_LOAD:   bank_data_nxt_s = data_nxt_s;
                    OP_CLEAR:  bank_clr_nxt_s  = 1'b1;
                    OP_PRESET: bank_pre_nxt_s  = 1'b1;
                    default:   bank_pre_nxt_s  = 1'b0;
                endcase
            end
            DONE:    ack_nxt_s = ack_vec(owner_r);
            default: ack_nxt_s = 2'b00;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bank_data_r <= {WIDTH{1'b0}};
            bank_clr_r  <= 1'b0;
            bank_pre_r  <= 1'b0;
            ack_r       <= 2'b00;
            rdata_r     <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            bank_data_r <= bank_data_nxt_s;
            bank_clr_r  <= bank_clr_nxt_s;
            bank_pre_r  <= bank_pre_nxt_s;
            ack_r       <= ack_nxt_s;
            rdata_r     <= rdata_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.bank_data = bank_data_r;
    assign bus.bank_clr  = bank_clr_r;
    assign bus.bank_pre  = bank_pre_r;
    assign bus.ack       = ack_r;
    assign bus.rdata     = rdata_r;
    assign bus.busy      = busy_r;
endmodule

// File: doc/ff_bank_arbiter.md
Name: ff_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of D flip-flops between two requesters. Each bank cell has async CLR/PRE and a DATA input sampled on the rising edge of CLK.
- Arbitrates requests round-robin and sequences the bank's DATA/CLR/PRE lines for each operation: load, clear, preset or read.
- Guarantees CLR and PRE are never high together, holds bank contents between operations, and returns a one-cycle ACK to the served requester.
- Sits between the requester logic and the flip-flop bank.

Parameters:
- WIDTH, 8, bank width in bits.
- PULSE_CYC, 2, cycles BANK_CLR/BANK_PRE stay asserted for a clear/preset; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR_N  in  1  asynchronous active-low reset.
- REQ  in  2  REQ[i] high = requester i wants an operation; held until ACK[i].
- OP0  in  2  requester 0 op: 00 LOAD, 01 CLEAR, 10 PRESET, 11 READ.
- OP1  in  2  requester 1 op, same encoding.
- DIN0  in  WIDTH  requester 0 load data.
- DIN1  in  WIDTH  requester 1 load data.
- BANK_Q  in  WIDTH  current bank outputs.
- BANK_DATA  out  WIDTH  bank DATA inputs.
- BANK_CLR  out  1  bank clear, active high.
- BANK_PRE  out  1  bank preset, active high.
- ACK  out  2  one-cycle completion pulse to the served requester.
- RDATA  out  WIDTH  bank value captured by the last READ.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- All outputs registered.
- BANK_DATA follows BANK_Q when not loading, so the bank holds its value.
- Reset (CLR_N low, async):
  - state IDLE; BANK_DATA, BANK_CLR, BANK_PRE, ACK, RDATA, BUSY all 0.
  - round-robin pointer favours requester 0; pulse counter 0.
- IDLE:
  - REQ sampled. If one bit is set, that requester wins.
  - If both bits are set, the requester not served last wins.
  - Latch owner, op and the owner's DIN, then go to EXEC. No request: stay in IDLE.
- EXEC:
  - LOAD: BANK_DATA = latched data for exactly 1 cycle.
  - CLEAR: BANK_CLR = 1 for PULSE_CYC cycles, counted by the pulse counter; BANK_PRE stays 0.
  - PRESET: BANK_PRE = 1 for PULSE_CYC cycles; BANK_CLR stays 0.
  - READ: RDATA <= BANK_Q, 1 cycle.
  - Then go to RECOVER.
- RECOVER:
  - 1 cycle; CLR/PRE low; BANK_DATA = BANK_Q.
  - Ensures the bank leaves its async state before the next op.
- DONE:
  - ACK[owner] = 1 for 1 cycle.
  - Pointer updated so the other requester has priority; return to IDLE.
  - REQ is ignored in DONE. A requester that keeps REQ high after ACK is treated as a new request in IDLE.
- Latency, from the IDLE edge that samples REQ:
  - LOAD/READ: ACK high 3 cycles later.
  - CLEAR/PRESET: ACK high PULSE_CYC+2 cycles later.
  - Back-to-back throughput: one op per latency+1 cycles.
- REQ dropped before ACK: the operation still completes and ACK still pulses.
- CLR_N low mid-operation: abort immediately, no ACK; bank contents are whatever was last applied.
- Invariant: BANK_CLR & BANK_PRE == 0 in every cycle.

Decomposition:
- Shared package holds:
  - op encodings OP_LOAD/OP_CLEAR/OP_PRESET/OP_READ;
  - state encoding IDLE/EXEC/RECOVER/DONE;
  - pulse counter width, 4 bits.
- One sub-module: rr_arb2 (2-way round-robin arbiter: REQ, advance strobe, one-hot grant, async active-low reset).

Test Plan (WIDTH=8, PULSE_CYC=2, bank of d_ff cells attached):
- Reset, then REQ=01, OP0=LOAD, DIN0=8'hA5 -> BANK_DATA=A5 for 1 cycle; ACK=01 3 cycles after sampling; BANK_Q=A5 afterwards and held.
- REQ=10, OP1=CLEAR -> BANK_CLR high exactly 2 cycles, BANK_PRE 0; ACK=10 at cycle 4; BANK_Q=00.
- REQ=11 held continuously, OP0=PRESET, OP1=READ -> ACK alternates 01, 10, 01...; after preset, READ returns RDATA=FF.
- Requester 0 sole repeat requester, REQ=01 held -> served every 4 cycles (LOAD); no starvation check for requester 1 once REQ=11.
- CLR_N pulled low during CLEAR EXEC -> BANK_CLR, ACK and BUSY drop to 0 immediately; no ACK after CLR_N returns high.
- Assertion over all tests: BANK_CLR and BANK_PRE never both 1; ACK never 2'b11; ACK width exactly 1 cycle.
